// File: rtl/ddr_wr_burst_engine.sv
// ddr_wr_burst_engine
//   DDR4 write-data path. Write bursts are queued in a small FIFO. Each WR
//   command drops a start token into a CWL-deep shift register. When the
//   token matures, the engine drives the DQS preamble, then rise/fall beat
//   pairs on DQ, then a one-cycle postamble. The PHY DDR-registers the
//   rise/fall pairs and derives DQS_c. All outputs are registered.
//
// Ports
//   CK_t_i          controller clock (posedge)
//   reset_i         async active-high reset
//   wr_valid_i      push request; wr_ready_o = FIFO not full
//   wr_data_i       burst data, beat0 in [DQ_W-1:0]
//   wr_bc4_i        1 = BC4 (4 beats), 0 = BL8
//   wr_cmd_i        WR command on the bus this cycle; cwl_i and pre2_i are sampled with it
//   dq_r_o/dq_f_o   beat on the rising/falling half of CK; dq_oe_o is the DQ drive enable
//   dqs_r_o/dqs_f_o DQS_t per half-cycle; dqs_oe_o is the DQS drive enable
//   busy_o          token pending or FSM active
//   err_underrun_o  sticky: burst started with the FIFO empty
//   err_overlap_o   sticky: burst due while a previous DATA phase was still running
module ddr_wr_burst_engine #(
    parameter int DQ_W    = 8,
    parameter int BL      = 8,
    parameter int DEPTH   = 4,
    parameter int CWL_MAX = 24
) (
    input  logic               CK_t_i,
    input  logic               reset_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [BL*DQ_W-1:0] wr_data_i,
    input  logic               wr_bc4_i,
    input  logic               wr_cmd_i,
    input  logic [4:0]         cwl_i,
    input  logic               pre2_i,
    output logic [DQ_W-1:0]    dq_r_o,
    output logic [DQ_W-1:0]    dq_f_o,
    output logic               dq_oe_o,
    output logic               dqs_r_o,
    output logic               dqs_f_o,
    output logic               dqs_oe_o,
    output logic               busy_o,
    output logic               err_underrun_o,
    output logic               err_overlap_o
);
    localparam int DW = BL * DQ_W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(BL) + 1;
    localparam logic [LW-1:0] LEFT_BL = LW'(BL / 2 - 1);
    localparam logic [LW-1:0] LEFT_BC = LW'(1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

    // ---------------- FIFO ----------------
    logic [DW:0]   mem_q [DEPTH];       // {bc4, data}
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, empty;
    logic [DW:0]   head;

    assign empty      = (count_q == '0);
    assign wr_ready_o = (count_q != (AW+1)'(DEPTH));
    assign push       = wr_valid_i && wr_ready_o;
    assign head       = mem_q[rptr_q];

    always_ff @(posedge CK_t_i) begin
        if (push) mem_q[wptr_q] <= {wr_bc4_i, wr_data_i};
    end

    always_ff @(posedge CK_t_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- start tokens ----------------
    // tok_q[i] set: a burst's first DATA cycle is i cycles from now.
    // tok_d is therefore the token view of the *next* cycle, which is what
    // the registered-output FSM needs to decide that cycle's outputs.
    logic [CWL_MAX-1:0] tok_q, tok_d, pre_q, pre_d, cmd_sel;

    always_comb begin
        for (int i = 0; i < CWL_MAX; i++)
            cmd_sel[i] = wr_cmd_i && (int'(cwl_i) == i + 1);
        tok_d = ({1'b0, tok_q[CWL_MAX-1:1]}) | cmd_sel;
        pre_d = (({1'b0, pre_q[CWL_MAX-1:1]}) & ~cmd_sel) | (cmd_sel & {CWL_MAX{pre2_i}});
    end

    // ---------------- burst FSM ----------------
    state_t            st_q, st_d;
    logic [LW-1:0]     left_q, left_d;       // DATA cycles still to come after the current one
    logic [DW-1:0]     sh_q, sh_d;           // remaining beats of the active burst
    logic              under_q, under_d;     // active burst has no data
    logic [DQ_W-1:0]   dq_r_q, dq_r_d, dq_f_q, dq_f_d;
    logic              dq_oe_q, dq_oe_d, dqs_r_q, dqs_r_d, dqs_oe_q, dqs_oe_d;
    logic              err_und_q, err_ovl_q, und_set, ovl_set;
    logic              start, pre_last, pre_first, data_cont, take;
    logic [DW-1:0]     src_data;
    logic              src_under;
    logic [LW-1:0]     src_left, head_left;

    assign start     = tok_d[0];
    assign pre_last  = tok_d[1];
    assign pre_first = tok_d[2] && pre_d[2];
    assign data_cont = (st_q == DATA) && (left_q != '0);
    assign head_left = (!empty && head[DW]) ? LEFT_BC : LEFT_BL;

    // 'take' loads a new burst from the FIFO head; otherwise the burst
    // already captured at preamble entry is used.
    always_comb begin
        take      = 1'b0;
        pop       = 1'b0;
        und_set   = 1'b0;
        ovl_set   = 1'b0;
        st_d      = IDLE;
        left_d    = left_q;
        sh_d      = sh_q;
        under_d   = under_q;
        dq_r_d    = '0;
        dq_f_d    = '0;
        dq_oe_d   = 1'b0;
        dqs_r_d   = 1'b0;
        dqs_oe_d  = 1'b0;

        if (data_cont) begin
            st_d     = DATA;
            take     = 1'b0;
            // A burst due now collides with the running one: drop it, but
            // still consume its data so later commands stay aligned.
            if (start) begin
                ovl_set = 1'b1;
                pop     = !empty;
            end
        end else if (start) begin
            st_d    = DATA;
            take    = (st_q != PRE);     // seamless continuation (or no preamble seen)
            pop     = take && !empty;
            und_set = take && empty;
        end else if (pre_last || pre_first) begin
            st_d     = PRE;
            dqs_oe_d = 1'b1;
            dqs_r_d  = pre_first && !pre_last;
            if (st_q != PRE) begin
                take    = 1'b1;
                pop     = !empty;
                und_set = empty;
            end
        end else if (st_q == DATA) begin
            st_d     = POST;
            dqs_oe_d = 1'b1;
        end

        src_data  = take ? head[DW-1:0] : sh_q;
        src_under = take ? empty : under_q;
        src_left  = take ? head_left : left_q;

        if (take) begin
            sh_d    = src_data;
            under_d = src_under;
            left_d  = src_left;
        end

        if (st_d == DATA) begin
            dqs_oe_d = 1'b1;
            dqs_r_d  = 1'b1;
            dq_oe_d  = !src_under;
            if (!src_under) begin
                dq_r_d = src_data[DQ_W-1:0];
                dq_f_d = src_data[2*DQ_W-1:DQ_W];
            end
            sh_d   = src_data >> (2 * DQ_W);
            left_d = data_cont ? left_q - LW'(1) : src_left;
        end
    end

    always_ff @(posedge CK_t_i or posedge reset_i) begin
        if (reset_i) begin
            tok_q     <= '0;
            pre_q     <= '0;
            st_q      <= IDLE;
            left_q    <= '0;
            sh_q      <= '0;
            under_q   <= 1'b0;
            dq_r_q    <= '0;
            dq_f_q    <= '0;
            dq_oe_q   <= 1'b0;
            dqs_r_q   <= 1'b0;
            dqs_oe_q  <= 1'b0;
            err_und_q <= 1'b0;
            err_ovl_q <= 1'b0;
        end else begin
            tok_q     <= tok_d;
            pre_q     <= pre_d;
            st_q      <= st_d;
            left_q    <= left_d;
            sh_q      <= sh_d;
            under_q   <= under_d;
            dq_r_q    <= dq_r_d;
            dq_f_q    <= dq_f_d;
            dq_oe_q   <= dq_oe_d;
            dqs_r_q   <= dqs_r_d;
            dqs_oe_q  <= dqs_oe_d;
            err_und_q <= err_und_q | und_set;
            err_ovl_q <= err_ovl_q | ovl_set;
        end
    end

    assign dq_r_o         = dq_r_q;
    assign dq_f_o         = dq_f_q;
    assign dq_oe_o        = dq_oe_q;
    assign dqs_r_o        = dqs_r_q;
    // DQS_t is never high in the falling half in any phase.
    assign dqs_f_o        = 1'b0;
    assign dqs_oe_o       = dqs_oe_q;
    assign busy_o         = (|tok_q) || (st_q != IDLE);
    assign err_underrun_o = err_und_q;
    assign err_overlap_o  = err_ovl_q;
endmodule

// File: tb/tb_ddr_wr_burst_engine.sv
module tb_ddr_wr_burst_engine;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_valid = 1'b0, wr_ready, wr_bc4 = 1'b0, wr_cmd = 1'b0, pre2 = 1'b0;
    logic [63:0] wr_data = '0;
    logic [4:0]  cwl = 5'd9;
    logic [7:0]  dq_r, dq_f;
    logic        dq_oe, dqs_r, dqs_f, dqs_oe, busy, err_und, err_ovl;
    int          nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    ddr_wr_burst_engine #(.DQ_W(8), .BL(8), .DEPTH(4), .CWL_MAX(24)) dut (
        .CK_t_i(clk), .reset_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_data_i(wr_data), .wr_bc4_i(wr_bc4), .wr_cmd_i(wr_cmd), .cwl_i(cwl),
        .pre2_i(pre2), .dq_r_o(dq_r), .dq_f_o(dq_f), .dq_oe_o(dq_oe),
        .dqs_r_o(dqs_r), .dqs_f_o(dqs_f), .dqs_oe_o(dqs_oe), .busy_o(busy),
        .err_underrun_o(err_und), .err_overlap_o(err_ovl));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {dq_oe, dqs_oe, dqs_r, dqs_f, dq_r, dq_f}
    task automatic out(input string tag, input logic doe, input logic soe, input logic sr,
                       input logic [7:0] r, input logic [7:0] f);
        chk(tag, {44'd0, dq_oe, dqs_oe, dqs_r, dqs_f, dq_r, dq_f},
                 {44'd0, doe, soe, sr, 1'b0, r, f});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] d, input logic bc4);
        wr_valid = 1'b1; wr_data = d; wr_bc4 = bc4;
        tick(1);
        wr_valid = 1'b0;
    endtask

    // Issue WR in the current cycle T; returns at T+1.
    task automatic cmd(input logic [4:0] c, input logic p2);
        wr_cmd = 1'b1; cwl = c; pre2 = p2;
        tick(1);
        wr_cmd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        a = 64'h0807_0605_0403_0201;
        b = 64'h2827_2625_2423_2221;
        tick(2);
        out("reset_outs", 0, 0, 0, 8'h00, 8'h00);
        chk("reset_ready", wr_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_errs", {err_und, err_ovl}, 0);
        rst = 1'b0;
        tick(1);

        // 1: BL8, cwl=9, 1tCK preamble
        push(a, 0);
        cmd(9, 0);                                        // now T+1
        chk("t1_busy", busy, 1);
        tick(6);  out("t1_idle_T7", 0, 0, 0, 8'h00, 8'h00);
        tick(1);  out("t1_pre_T8", 0, 1, 0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            out("t1_data", 1, 1, 1, 8'(2*k+1), 8'(2*k+2));
        end
        tick(1);  out("t1_post_T13", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t1_idle_T14", 0, 0, 0, 8'h00, 8'h00);
        chk("t1_busy_end", busy, 0);

        // 2: 2tCK preamble, cwl=12
        push(64'h1817_1615_1413_1211, 0);
        cmd(12, 1);                                       // T+1
        tick(8);  out("t2_idle_T9", 0, 0, 0, 8'h00, 8'h00);
        tick(1);  out("t2_pre1_T10", 0, 1, 1, 8'h00, 8'h00);
        tick(1);  out("t2_pre2_T11", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t2_data0_T12", 1, 1, 1, 8'h11, 8'h12);
        tick(4);  out("t2_post_T16", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  chk("t2_busy_end", busy, 0);

        // 3: seamless back-to-back, WR at T and T+4
        push(a, 0);
        push(b, 0);
        cmd(9, 0);                                        // T+1
        tick(3);                                          // T+4
        cmd(9, 0);                                        // T+5
        tick(3);  out("t3_pre_T8", 0, 1, 0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            out("t3_data", 1, 1, 1, 8'(((k/4)*8'h20) + 2*(k%4) + 1),
                                    8'(((k/4)*8'h20) + 2*(k%4) + 2));
        end
        tick(1);  out("t3_post_T17", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t3_idle_T18", 0, 0, 0, 8'h00, 8'h00);

        // 4: BC4 burst, FIFO full
        push(64'h3837_3635_3433_3231, 1);
        push(64'h4847_4645_4443_4241, 0);
        push(64'h5857_5655_5453_5251, 0);
        push(64'h6867_6665_6463_6261, 0);
        chk("t4_full_ready", wr_ready, 0);
        cmd(6, 0);                                        // T+1
        tick(3);  chk("t4_ready_T4", wr_ready, 0);
        tick(1);  chk("t4_ready_T5", wr_ready, 1);
        out("t4_pre_T5", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t4_data0", 1, 1, 1, 8'h31, 8'h32);
        tick(1);  out("t4_data1", 1, 1, 1, 8'h33, 8'h34);
        tick(1);  out("t4_post", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t4_idle", 0, 0, 0, 8'h00, 8'h00);

        // 6: reset during DATA
        cmd(6, 0);                                        // T+1
        tick(5);  out("t6_data0", 1, 1, 1, 8'h41, 8'h42);
        tick(1);  out("t6_data1", 1, 1, 1, 8'h43, 8'h44);
        #2 rst = 1'b1;
        #1;
        out("t6_rst_outs", 0, 0, 0, 8'h00, 8'h00);
        chk("t6_rst_ready", wr_ready, 1);
        chk("t6_rst_busy", busy, 0);
        #1 rst = 1'b0;
        tick(1);
        push(64'h7877_7675_7473_7271, 0);
        cmd(5, 1);                                        // T+1
        tick(2);  out("t6_pre1_T3", 0, 1, 1, 8'h00, 8'h00);
        tick(1);  out("t6_pre2_T4", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t6_data0_T5", 1, 1, 1, 8'h71, 8'h72);
        tick(3);  out("t6_data3_T8", 1, 1, 1, 8'h77, 8'h78);
        tick(1);  out("t6_post_T9", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  chk("t6_busy_end", busy, 0);
        chk("t6_errs_clear", {err_und, err_ovl}, 0);

        // 5a: underrun
        cmd(9, 0);                                        // T+1
        tick(6);  chk("t5_und_T7", err_und, 0);
        tick(1);  chk("t5_und_T8", err_und, 1);
        out("t5_und_pre", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  out("t5_und_data", 0, 1, 1, 8'h00, 8'h00);
        tick(5);  chk("t5_und_idle", busy, 0);

        // 5b: overlap, WR at T and T+2
        push(64'h9897_9695_9493_9291, 0);
        push(64'hA8A7_A6A5_A4A3_A2A1, 0);
        cmd(9, 0);                                        // T+1
        tick(1);                                          // T+2
        cmd(9, 0);                                        // T+3
        tick(6);  out("t5_ovl_T9", 1, 1, 1, 8'h91, 8'h92);
        chk("t5_ovl_T9_flag", err_ovl, 0);
        tick(1);  chk("t5_ovl_T10_flag", err_ovl, 0);
        tick(1);  chk("t5_ovl_T11_flag", err_ovl, 1);
        out("t5_ovl_T11", 1, 1, 1, 8'h95, 8'h96);
        tick(1);  out("t5_ovl_T12", 1, 1, 1, 8'h97, 8'h98);
        tick(1);  out("t5_ovl_post", 0, 1, 0, 8'h00, 8'h00);
        tick(1);  chk("t5_ovl_idle", busy, 0);
        chk("t5_ovl_ready", wr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
